// File: rtl/noc_output_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// noc_output_arbiter
//
// Output-port arbiter for a wormhole-routed network-on-chip router. Up to
// PORTS requesters compete for one registered output stage.
//
// Arbitration:
//   * IDLE:   round-robin among requesters offering a head or single flit.
//             A head grant locks the output to that requester (LOCKED).
//             A single grant is a complete packet, so the arbiter stays IDLE.
//   * LOCKED: only the owner may send. Every flit it offers is forwarded
//             until its tail is accepted, then the arbiter returns to IDLE.
//             The lock is held for as long as it takes; there is no timeout.
//
// Flit type lives in the top two bits of every flit:
//   00 single, 01 head, 10 body, 11 tail.
//
// Parameters:
//   FLIT_WIDTH  flit width in bits (default 64)
//   PORTS       number of requesters, 2..8 (default 5)
//
// Ports:
//   clk          the only clock, rising edge
//   rst_n        synchronous active-low reset
//   req_flit     flit offered by each requester
//   req_valid    requester i offers a flit
//   req_ready    flit of requester i is accepted this cycle when valid
//   out_flit     registered output flit
//   out_valid    out_flit holds a flit
//   out_ready    downstream accepts out_flit
//   lock_active  a wormhole lock is held
//   owner        index of the current or last-granted requester
//   stat_pkts    completed-packet counter
//
// Build option:
//   NOC_ARB_STATS_EN  when defined, stat_pkts counts accepted singles (IDLE)
//                     and tails (LOCKED), wrapping at 2^32. When undefined,
//                     no counter is built and stat_pkts reads 0.
// -----------------------------------------------------------------------------
module noc_output_arbiter #(
  parameter int FLIT_WIDTH = 64,
  parameter int PORTS      = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS-1:0][FLIT_WIDTH-1:0] req_flit,
  input  logic [PORTS-1:0]                 req_valid,
  output logic [PORTS-1:0]                 req_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             lock_active,
  output logic [2:0]                       owner,
  output logic [31:0]                      stat_pkts
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  // Registered state
  state_t                  state_reg;
  state_t                  state_next;
  logic [2:0]              rr_ptr_reg;
  logic [2:0]              rr_ptr_next;
  logic [2:0]              owner_reg;
  logic [2:0]              owner_next;
  logic                    out_valid_reg;
  logic                    out_valid_next;
  logic [FLIT_WIDTH-1:0]   out_flit_reg;
  logic [FLIT_WIDTH-1:0]   out_flit_next;

  // Per-requester decode
  logic [PORTS-1:0][1:0]   flit_type;
  logic [PORTS-1:0]        eligible;

  // Arbitration results
  logic                    found;
  logic [2:0]              winner;
  logic                    space;
  logic [PORTS-1:0]        accept_vec;
  logic                    accept;
  logic [FLIT_WIDTH-1:0]   acc_flit;
  logic [1:0]              acc_type;

  // ---------------------------------------------------------------------------
  // Flit type decode. Only heads and singles may open a new packet, and both
  // have a zero MSB in the type field.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_decode
      assign flit_type[gi] = req_flit[gi][FLIT_WIDTH-1 -: 2];
      assign eligible[gi]  = req_valid[gi] && !flit_type[gi][1];
    end
  endgenerate

  // The output register can take a new flit if it is empty or draining now.
  assign space = !out_valid_reg || out_ready;

  // ---------------------------------------------------------------------------
  // Round-robin search: first eligible index starting at rr_ptr, wrapping
  // modulo PORTS. The candidate index is computed in 4 bits so that
  // rr_ptr + offset cannot overflow before the modulo correction, and the
  // eligibility bit is picked with a compare loop so that any PORTS in 2..8
  // indexes cleanly.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [3:0] cand;
    logic       cand_elig;
    found     = 1'b0;
    winner    = 3'd0;
    cand      = 4'd0;
    cand_elig = 1'b0;
    for (int off = 0; off < PORTS; off++) begin
      cand = {1'b0, rr_ptr_reg} + 4'(off);
      if (cand >= 4'(PORTS)) begin
        cand = cand - 4'(PORTS);
      end
      cand_elig = 1'b0;
      for (int j = 0; j < PORTS; j++) begin
        if (cand == 4'(j)) begin
          cand_elig = eligible[j];
        end
      end
      if (!found && cand_elig) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ready generation. In LOCKED the owner sees space directly, whether or not
  // it is currently offering a flit. Ready is held low while in reset so
  // nothing is handshaken on a reset edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (rst_n && space) begin
      if (state_reg == ST_IDLE) begin
        for (int i = 0; i < PORTS; i++) begin
          if (found && (winner == 3'(i))) begin
            req_ready[i] = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < PORTS; i++) begin
          if (owner_reg == 3'(i)) begin
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  assign accept_vec = req_valid & req_ready;
  assign accept     = |accept_vec;

  // accept_vec is at most one-hot, so a priority-free OR-style mux is safe.
  always_comb begin
    acc_flit = '0;
    acc_type = FT_SINGLE;
    for (int i = 0; i < PORTS; i++) begin
      if (accept_vec[i]) begin
        acc_flit = req_flit[i];
        acc_type = flit_type[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, round-robin pointer, owner and output register.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    out_valid_next = out_valid_reg;
    out_flit_next  = out_flit_reg;

    if (accept) begin
      // Load and drain can coincide, giving one flit per cycle without bubbles.
      out_valid_next = 1'b1;
      out_flit_next  = acc_flit;
      case (state_reg)
        ST_IDLE: begin
          owner_next  = winner;
          rr_ptr_next = (winner == 3'(PORTS-1)) ? 3'd0 : winner + 3'd1;
          // Only head or single can be accepted here; single ends immediately.
          if (acc_type == FT_HEAD) begin
            state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Arbitration resumes on the very next cycle after the tail.
          if (acc_type == FT_TAIL) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= 3'd0;
      owner_reg     <= 3'd0;
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      out_valid_reg <= out_valid_next;
      out_flit_reg  <= out_flit_next;
    end
  end

  assign out_flit    = out_flit_reg;
  assign out_valid   = out_valid_reg;
  assign lock_active = (state_reg == ST_LOCKED);
  assign owner       = owner_reg;

  // ---------------------------------------------------------------------------
  // Optional completed-packet counter.
  // ---------------------------------------------------------------------------
`ifdef NOC_ARB_STATS_EN
  logic [31:0] stat_pkts_reg;
  logic        pkt_done;

  assign pkt_done = accept &&
                    (((state_reg == ST_IDLE)   && (acc_type == FT_SINGLE)) ||
                     ((state_reg == ST_LOCKED) && (acc_type == FT_TAIL)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkts_reg <= 32'd0;
    end else if (pkt_done) begin
      stat_pkts_reg <= stat_pkts_reg + 32'd1;
    end
  end

  assign stat_pkts = stat_pkts_reg;
`else
  assign stat_pkts = 32'd0;
`endif

endmodule
